// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: bit order, hex code table and capture FSM states.
// The display-driver side uses the same constants so both ends agree on the encoding.
package seg7_pkg;

    localparam int SEG_W = 7;

    // Segment line order on the bus: {a,b,c,d,e,f,g}, a in the MSB.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_HA    = 7'b1110111;
    localparam logic [6:0] SEG_HB    = 7'b0011111;
    localparam logic [6:0] SEG_HC    = 7'b1001110;
    localparam logic [6:0] SEG_HD    = 7'b0111101;
    localparam logic [6:0] SEG_HE    = 7'b1001111;
    localparam logic [6:0] SEG_HF    = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_HELD   = 1'b1;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational reverse lookup of a 7-segment pattern into a hex nibble.
// All-off reports blank, anything outside the table reports invalid; both give nibble 0.
module seg7_pattern_decoder
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       invalid
);

    // Table lookup with blank/invalid classification
    always_comb begin
        nibble  = 4'h0;
        blank   = 1'b0;
        invalid = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_HA:    nibble = 4'hA;
            SEG_HB:    nibble = 4'hB;
            SEG_HC:    nibble = 4'hC;
            SEG_HD:    nibble = 4'hD;
            SEG_HE:    nibble = 4'hE;
            SEG_HF:    nibble = 4'hF;
            SEG_BLANK: blank   = 1'b1;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Samples a scanned 7-segment bus, captures each digit once it has been stable,
// and presents the assembled frame on a valid/ready output with sticky overrun.
module seven_segment_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_en,
    input  logic                  out_ready,
    input  logic                  ovr_clr,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     invalid,
    output logic                  ovr
);

    localparam logic [7:0] STABLE_C = 8'(STABLE);

    logic [DIGITS+6:0]   samp_r;
    logic [DIGITS+6:0]   cur_s;
    logic [7:0]          run_r;
    logic [7:0]          run_nxt_s;
    logic [DIGITS-1:0]   state_r;
    logic [DIGITS-1:0]   mask_r;
    logic [DIGITS-1:0]   cap_s;
    logic [4*DIGITS-1:0] slot_val_r;
    logic [DIGITS-1:0]   slot_blank_r;
    logic [DIGITS-1:0]   slot_inv_r;
    logic [4*DIGITS-1:0] mval_s;
    logic [DIGITS-1:0]   mblank_s;
    logic [DIGITS-1:0]   minv_s;
    logic                change_s;
    logic                onehot_s;
    logic                full_s;
    logic                load_s;
    logic                drop_s;
    logic [3:0]          nib_s;
    logic                dec_blank_s;
    logic                dec_inv_s;

    seg7_pattern_decoder u_dec (
        .seg     (seg),
        .nibble  (nib_s),
        .blank   (dec_blank_s),
        .invalid (dec_inv_s)
    );

    assign cur_s    = {seg, dig_en};
    assign change_s = (cur_s != samp_r);
    assign onehot_s = (dig_en != '0) && ((dig_en & (dig_en - DIGITS'(1))) == '0);

    // Run length of identical samples, saturating at the stability threshold
    always_comb begin
        if (change_s) begin
            run_nxt_s = 8'd1;
        end else if (run_r >= STABLE_C) begin
            run_nxt_s = STABLE_C;
        end else begin
            run_nxt_s = run_r + 8'd1;
        end
    end

    // Capture decision per digit and merge of this edge's capture into the slots
    always_comb begin
        cap_s    = '0;
        mval_s   = slot_val_r;
        mblank_s = slot_blank_r;
        minv_s   = slot_inv_r;
        for (int i = 0; i < DIGITS; i++) begin
            cap_s[i]          = (run_nxt_s == STABLE_C) && onehot_s && dig_en[i] &&
                                (state_r[i] == ST_SETTLE[0]);
            mval_s[4*i +: 4]  = cap_s[i] ? nib_s : slot_val_r[4*i +: 4];
            mblank_s[i]       = cap_s[i] ? dec_blank_s : slot_blank_r[i];
            minv_s[i]         = cap_s[i] ? dec_inv_s : slot_inv_r[i];
        end
        full_s = &(mask_r | cap_s);
        load_s = full_s && (!out_valid || out_ready);
        drop_s = full_s && out_valid && !out_ready;
    end

    // Sample register, run counter, per-digit FSMs, slots and frame mask
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_r       <= '0;
            run_r        <= 8'd0;
            state_r      <= '0;
            mask_r       <= '0;
            slot_val_r   <= '0;
            slot_blank_r <= '0;
            slot_inv_r   <= '0;
        end else begin
            samp_r       <= cur_s;
            run_r        <= run_nxt_s;
            slot_val_r   <= mval_s;
            slot_blank_r <= mblank_s;
            slot_inv_r   <= minv_s;
            mask_r       <= full_s ? '0 : (mask_r | cap_s);
            for (int i = 0; i < DIGITS; i++) begin
                if (cap_s[i]) begin
                    state_r[i] <= ST_HELD[0];
                end else if (change_s) begin
                    state_r[i] <= ST_SETTLE[0];
                end
            end
        end
    end

    // Output register with valid/ready handshake; a full frame is dropped only when stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            value     <= '0;
            blank     <= '0;
            invalid   <= '0;
            ovr       <= 1'b0;
        end else begin
            if (load_s) begin
                out_valid <= 1'b1;
                value     <= mval_s;
                blank     <= mblank_s;
                invalid   <= minv_s;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop_s) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Scoreboard bench: expected frames are queued as digits are driven and
// compared whenever the decoder hands a frame over on valid/ready.
module tb_seven_segment_scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        out_ready;
    logic        ovr_clr;
    logic        out_valid;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  invalid;
    logic        ovr;

    int checks = 0;
    int errors = 0;
    logic [23:0] sb_q[$];

    logic [6:0] enc [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    always #5 clk = ~clk;

    seven_segment_scan_decoder #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .dig_en    (dig_en),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .out_valid (out_valid),
        .value     (value),
        .blank     (blank),
        .invalid   (invalid),
        .ovr       (ovr)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_digit(input int idx, input logic [6:0] s, input int n);
        dig_en = 4'(1 << idx);
        seg    = s;
        step(n);
    endtask

    task automatic send_frame(input logic [15:0] v);
        for (int i = 0; i < DIGITS; i++) begin
            send_digit(i, enc[v[4*i +: 4]], STABLE);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"},   32'(out_valid), 32'd0);
        check_val({tag, "_value"},   32'(value),     32'd0);
        check_val({tag, "_blank"},   32'(blank),     32'd0);
        check_val({tag, "_invalid"}, 32'(invalid),   32'd0);
        check_val({tag, "_ovr"},     32'(ovr),       32'd0);
    endtask

    // Inputs change just after posedge, so at negedge they show what the next edge samples
    always @(negedge clk) begin
        logic [23:0] exp_frame;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_frame = sb_q.pop_front();
                check_val("frame", 32'({invalid, blank, value}), 32'(exp_frame));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        seg       = 7'b0000000;
        dig_en    = 4'b0000;
        out_ready = 1'b1;
        ovr_clr   = 1'b0;
        step(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic frame: out_valid on exactly the 16th edge
        sb_q.push_back({4'b0000, 4'b0000, 16'h90F2});
        send_digit(0, enc[2], 4);
        send_digit(1, enc[15], 4);
        send_digit(2, enc[0], 4);
        send_digit(3, enc[9], 3);
        check_val("t1_early", 32'(out_valid), 32'd0);
        step(1);
        check_val("t1_valid_16th", 32'(out_valid), 32'd1);
        check_val("t1_value", 32'(value), 32'h90F2);
        step(1);
        check_val("t1_valid_after_xfer", 32'(out_valid), 32'd0);

        // Three-cycle hold on digit 0 must not capture
        send_digit(0, enc[5], 3);
        send_digit(1, enc[3], 4);
        send_digit(2, enc[12], 4);
        send_digit(3, enc[7], 4);
        check_val("t2_short_hold", 32'(out_valid), 32'd0);
        sb_q.push_back({4'b0000, 4'b0000, 16'h7C3A});
        send_digit(0, enc[10], 4);
        check_val("t2_valid", 32'(out_valid), 32'd1);
        step(1);

        // Blank and non-table patterns
        sb_q.push_back({4'b0100, 4'b0010, 16'hB00E});
        send_digit(0, enc[14], 4);
        send_digit(1, 7'b0000000, 4);
        send_digit(2, 7'b1010101, 4);
        send_digit(3, enc[11], 4);
        check_val("t3_blank", 32'(blank), 32'h2);
        check_val("t3_invalid", 32'(invalid), 32'h4);
        step(1);

        // Stalled consumer: second frame dropped, first held, ovr sticky until cleared
        out_ready = 1'b0;
        sb_q.push_back({4'b0000, 4'b0000, 16'h1234});
        send_frame(16'h1234);
        check_val("t4_valid", 32'(out_valid), 32'd1);
        check_val("t4_ovr_before", 32'(ovr), 32'd0);
        send_frame(16'h5678);
        check_val("t4_ovr_set", 32'(ovr), 32'd1);
        check_val("t4_hold_value", 32'(value), 32'h1234);
        check_val("t4_hold_valid", 32'(out_valid), 32'd1);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        check_val("t4_ovr_clr", 32'(ovr), 32'd0);
        out_ready = 1'b1;
        step(1);
        check_val("t4_valid_after_xfer", 32'(out_valid), 32'd0);

        // Multi-hot digit enable never captures or disturbs the slots
        sb_q.push_back({4'b0000, 4'b0000, 16'h4DA6});
        send_digit(0, enc[6], 4);
        send_digit(1, enc[10], 4);
        send_digit(2, enc[13], 4);
        dig_en = 4'b0011;
        seg    = enc[8];
        step(10);
        check_val("t5_multi_hot", 32'(out_valid), 32'd0);
        send_digit(3, enc[4], 4);
        check_val("t5_valid", 32'(out_valid), 32'd1);
        check_val("t5_value", 32'(value), 32'h4DA6);
        step(1);

        // Reset mid-frame discards the two captured digits
        send_digit(0, enc[1], 4);
        send_digit(1, enc[1], 4);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_reset_outputs("t6_reset");
        send_digit(2, enc[3], 4);
        send_digit(3, enc[3], 4);
        check_val("t6_partial_discarded", 32'(out_valid), 32'd0);
        sb_q.push_back({4'b0000, 4'b0000, 16'h33CC});
        send_digit(0, enc[12], 4);
        send_digit(1, enc[12], 4);
        check_val("t6_valid", 32'(out_valid), 32'd1);
        step(2);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
